// File: rtl/stream_mux_pkg.sv
// Shared mode constants and output-stage state type for the stream multiplexor.
package stream_mux_pkg;

    localparam logic MUX_MODE_SEL = 1'b0;
    localparam logic MUX_MODE_RR  = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } mux_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo NUM_CH.
// Zero latency; en=0 suppresses any grant so the caller can apply output backpressure.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_grant,
    input  logic              en,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        // Offsets 1..NUM_CH so the previous winner is considered last.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = SEL_W'((int'(last_grant) + k) % NUM_CH);
            if (en && !gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// NUM_CH:1 valid/ready stream mux, external select or round-robin; beat_cnt port exists only with MUX_CNT_EN.
// One-cycle registered output; a stalled output holds its beat and drops every in_ready.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
`ifdef MUX_CNT_EN
    ,
    output logic [15:0]              beat_cnt
`endif
);

    mux_state_t       state;
    logic [SEL_W-1:0] last_grant;
    logic             load_en;
    logic             sel_hit;
    logic             arb_valid;
    logic [SEL_W-1:0] arb_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [DATA_W-1:0] ch_data [NUM_CH];

    assign load_en = !out_valid || out_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = in_data[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req        (in_valid),
        .last_grant (last_grant),
        .en         (load_en && (mode == MUX_MODE_RR)),
        .gnt_valid  (arb_valid),
        .gnt_idx    (arb_idx)
    );

    // An out-of-range sel never indexes in_valid, so it can never grant.
    always_comb begin
        sel_hit = 1'b0;
        if (int'(sel) < NUM_CH) begin
            sel_hit = in_valid[sel];
        end
        if (mode == MUX_MODE_RR) begin
            gnt_valid = arb_valid;
            gnt_idx   = arb_idx;
        end else begin
            gnt_valid = load_en && sel_hit;
            gnt_idx   = sel;
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = gnt_valid && (gnt_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
        end else begin
            if (gnt_valid) begin
                out_data   <= ch_data[gnt_idx];
                out_ch     <= gnt_idx;
                last_grant <= gnt_idx;
            end
            case (state)
                EMPTY: begin
                    if (gnt_valid) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    // A grant in FULL implies out_ready, so the new beat replaces the old one.
                    if (out_ready && !gnt_valid) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end
`endif

endmodule
